// File: rtl/wb_pkg.sv
// Shared widths and types for the register-file write-port arbiter and its load queue.
package wb_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
      logic              kill;
   } lq_entry_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_PIPE,
      GNT_LOAD
   } gnt_src_t;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-response queue: circular buffer with registered count/ready and a
// broadcast kill-by-rd port that marks matching entries as dead.
module wb_load_fifo import wb_pkg::*; #(
   parameter int LQ_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  lq_entry_t         push_entry,
   input  logic              pop,
   input  logic              kill_en,
   input  logic [REG_AW-1:0] kill_rd,
   output lq_entry_t         head,
   output logic              full,
   output logic              empty,
   output logic              ready
);

   localparam int PW = $clog2(LQ_DEPTH);
   localparam int CW = $clog2(LQ_DEPTH + 1);

   lq_entry_t     mem [LQ_DEPTH];
   lq_entry_t     wr_entry;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;

   // An entry arriving alongside a matching pipeline grant counts as older, so it dies on entry.
   always_comb begin
      wr_entry = push_entry;
      if (kill_en && (push_entry.rd == kill_rd)) begin
         wr_entry.kill = 1'b1;
      end
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop) begin
         count_nxt = count + 1'b1;
      end else if (pop && !push) begin
         count_nxt = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         ready  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
         ready <= (count_nxt != CW'(LQ_DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < LQ_DEPTH; i++) begin
         if (push && (wr_ptr == PW'(i))) begin
            mem[i] <= wr_entry;
         end else if (kill_en && (mem[i].rd == kill_rd)) begin
            mem[i].kill <= 1'b1;
         end
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(LQ_DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between pipeline write-back
// and queued load responses, with starvation bound and WAW cancellation.
module wb_port_arbiter import wb_pkg::*; #(
   parameter int XLEN       = wb_pkg::XLEN,
   parameter int REG_AW     = wb_pkg::REG_AW,
   parameter int LQ_DEPTH   = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pipe_valid,
   input  logic [REG_AW-1:0] pipe_rd,
   input  logic [XLEN-1:0]   pipe_data,
   output logic              pipe_stall,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [REG_AW-1:0] ld_rd,
   input  logic [XLEN-1:0]   ld_data,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_waddr,
   output logic [XLEN-1:0]   rf_wdata
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
      return (v == SW'(STARVE_MAX)) ? v : v + 1'b1;
   endfunction

   lq_entry_t     push_entry;
   lq_entry_t     head;
   logic          q_full;
   logic          q_empty;
   logic          push;
   logic          pop;
   logic          h_live;
   logic          p_req;
   logic          forced;
   gnt_src_t      gnt;
   logic [SW-1:0] starve_cnt;
   logic [SW-1:0] starve_nxt;

   assign push = ld_valid && ld_ready;

   always_comb begin
      push_entry      = '0;
      push_entry.rd   = ld_rd;
      push_entry.data = ld_data;
      push_entry.kill = (ld_rd == '0);
   end

   wb_load_fifo #(
      .LQ_DEPTH (LQ_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .kill_en    (gnt == GNT_PIPE),
      .kill_rd    (pipe_rd),
      .head       (head),
      .full       (q_full),
      .empty      (q_empty),
      .ready      (ld_ready)
   );

   // Full or starved queue overrides the pipeline; a dead head never forces a stall.
   always_comb begin
      h_live     = !q_empty && !head.kill;
      p_req      = pipe_valid && (pipe_rd != '0);
      forced     = h_live && (q_full || (starve_cnt == SW'(STARVE_MAX)));
      gnt        = GNT_NONE;
      starve_nxt = starve_cnt;
      if (forced) begin
         gnt = GNT_LOAD;
      end else if (p_req) begin
         gnt = GNT_PIPE;
      end else if (h_live) begin
         gnt = GNT_LOAD;
      end
      if (q_empty || (gnt == GNT_LOAD)) begin
         starve_nxt = '0;
      end else if (gnt == GNT_PIPE) begin
         starve_nxt = sat_inc(starve_cnt);
      end
      pop        = (gnt == GNT_LOAD) || (!q_empty && head.kill);
      pipe_stall = pipe_valid && forced;
   end

   // Write-port register stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         starve_cnt <= '0;
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         rf_we      <= 1'b0;
         case (gnt)
            GNT_PIPE: begin
               rf_we    <= 1'b1;
               rf_waddr <= pipe_rd;
               rf_wdata <= pipe_data;
            end
            GNT_LOAD: begin
               rf_we    <= 1'b1;
               rf_waddr <= head.rd;
               rf_wdata <= head.data;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_wb_port_arbiter;

   localparam int LQ_DEPTH   = 2;
   localparam int STARVE_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pv;
   logic [4:0]  prd;
   logic [31:0] pdat;
   logic        lv;
   logic [4:0]  lrd;
   logic [31:0] ldat;
   logic        pipe_stall;
   logic        ld_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   always #5 clk = ~clk;

   wb_port_arbiter #(
      .LQ_DEPTH   (LQ_DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pipe_valid (pv),
      .pipe_rd    (prd),
      .pipe_data  (pdat),
      .pipe_stall (pipe_stall),
      .ld_valid   (lv),
      .ld_ready   (ld_ready),
      .ld_rd      (lrd),
      .ld_data    (ldat),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      bit          kill;
   } ment_t;

   ment_t       mq[$];
   int          m_starve = 0;
   bit          m_ready  = 1'b0;
   bit          m_we     = 1'b0;
   logic [4:0]  m_addr   = '0;
   logic [31:0] m_data   = '0;
   int          m_win;
   bit          exp_stall;
   bit          exp_ready;
   logic        act_stall;
   logic        act_ready;

   task automatic set_idle();
      pv = 1'b0; prd = '0; pdat = '0;
      lv = 1'b0; lrd = '0; ldat = '0;
   endtask

   // One clock: sample combinational/pre-edge outputs, advance the model, settle after the edge.
   task automatic tick();
      bit ne, live, full, forced, preq, accepted;
      @(negedge clk);
      #1;
      ne     = (mq.size() != 0);
      live   = ne && !mq[0].kill;
      full   = (mq.size() == LQ_DEPTH);
      forced = live && (full || (m_starve == STARVE_MAX));
      preq   = pv && (prd != 0);
      m_win  = forced ? 2 : (preq ? 1 : (live ? 2 : 0));
      exp_stall = pv && forced;
      exp_ready = m_ready;
      act_stall = pipe_stall;
      act_ready = ld_ready;
      @(posedge clk);
      if (!rst_n) begin
         mq.delete();
         m_starve = 0;
         m_ready  = 1'b0;
         m_we     = 1'b0;
         m_addr   = '0;
         m_data   = '0;
      end else begin
         accepted = lv && m_ready;
         m_we = 1'b0;
         if (m_win == 1) begin
            m_we = 1'b1; m_addr = prd; m_data = pdat;
         end else if (m_win == 2) begin
            m_we = 1'b1; m_addr = mq[0].rd; m_data = mq[0].data;
         end
         if (m_win == 2 || (ne && mq[0].kill)) void'(mq.pop_front());
         if (m_win == 1) begin
            foreach (mq[i]) if (mq[i].rd == prd) mq[i].kill = 1'b1;
         end
         if (accepted) mq.push_back('{lrd, ldat, (lrd == 0) || (m_win == 1 && lrd == prd)});
         if (!ne || m_win == 2) m_starve = 0;
         else if (m_win == 1 && m_starve < STARVE_MAX) m_starve++;
         m_ready = (mq.size() != LQ_DEPTH);
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_idle();
      tick();
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_we); end
      total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
      total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
      total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ld_ready); end
      rst_n = 1'b1;
      tick();
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", ld_ready); end
   endtask

   task automatic test_pipe_only();
      set_idle();
      pv = 1'b1; prd = 5'd5; pdat = 32'h1234;
      tick();
      total++; if (act_stall !== 1'b0) begin bad++; $display("FAIL pipe_stall got=%b exp=0", act_stall); end
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL pipe_we got=%b exp=1", rf_we); end
      total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL pipe_waddr got=%0d exp=5", rf_waddr); end
      total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL pipe_wdata got=%h exp=1234", rf_wdata); end
      set_idle();
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL idle_we got=%b exp=0", rf_we); end
      total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL hold_waddr got=%0d exp=5", rf_waddr); end
      total++; if (rf_wdata !== 32'h1234) begin bad++; $display("FAIL hold_wdata got=%h exp=1234", rf_wdata); end
   endtask

   task automatic test_load_idle();
      set_idle();
      lv = 1'b1; lrd = 5'd7; ldat = 32'hDEADBEEF;
      tick();
      total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL ld_ready_accept got=%b exp=1", act_ready); end
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ld_early_we got=%b exp=0", rf_we); end
      set_idle();
      tick();
      total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL ld_ready_hold got=%b exp=1", act_ready); end
      total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL ld_we got=%b exp=1", rf_we); end
      total++; if (rf_waddr !== 5'd7) begin bad++; $display("FAIL ld_waddr got=%0d exp=7", rf_waddr); end
      total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_wdata got=%h exp=deadbeef", rf_wdata); end
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ld_after_we got=%b exp=0", rf_we); end
   endtask

   task automatic test_full();
      set_idle();
      pv = 1'b1; prd = 5'd9; pdat = 32'h99;
      lv = 1'b1; lrd = 5'd10; ldat = 32'hA0;
      tick();
      total++; if (rf_waddr !== 5'd9) begin bad++; $display("FAIL full_t1_waddr got=%0d exp=9", rf_waddr); end
      lrd = 5'd11; ldat = 32'hB0;
      tick();
      total++; if (act_stall !== 1'b0) begin bad++; $display("FAIL full_t2_stall got=%b exp=0", act_stall); end
      total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", ld_ready); end
      lv = 1'b0;
      tick();
      total++; if (act_stall !== 1'b1) begin bad++; $display("FAIL full_stall got=%b exp=1", act_stall); end
      total++; if (act_ready !== 1'b0) begin bad++; $display("FAIL full_ready_pre got=%b exp=0", act_ready); end
      total++; if (rf_waddr !== 5'd10 || rf_wdata !== 32'hA0 || rf_we !== 1'b1) begin
         bad++; $display("FAIL full_load_win got=%b/%0d/%h exp=1/10/a0", rf_we, rf_waddr, rf_wdata); end
      tick();
      total++; if (act_stall !== 1'b0) begin bad++; $display("FAIL full_t4_stall got=%b exp=0", act_stall); end
      total++; if (act_ready !== 1'b1) begin bad++; $display("FAIL full_t4_ready got=%b exp=1", act_ready); end
      total++; if (rf_waddr !== 5'd9) begin bad++; $display("FAIL full_t4_waddr got=%0d exp=9", rf_waddr); end
      pv = 1'b0;
      tick();
      total++; if (rf_waddr !== 5'd11 || rf_wdata !== 32'hB0) begin
         bad++; $display("FAIL full_second_load got=%0d/%h exp=11/b0", rf_waddr, rf_wdata); end
      set_idle();
      tick();
   endtask

   task automatic test_starve();
      set_idle();
      pv = 1'b1; prd = 5'd13; pdat = 32'hD;
      lv = 1'b1; lrd = 5'd12; ldat = 32'hC;
      tick();
      total++; if (act_stall !== 1'b0 || rf_waddr !== 5'd13) begin
         bad++; $display("FAIL starve_t0 got=%b/%0d exp=0/13", act_stall, rf_waddr); end
      lv = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         total++; if (act_stall !== (i == 5)) begin
            bad++; $display("FAIL starve_stall cyc=%0d got=%b exp=%b", i, act_stall, (i == 5)); end
         total++; if (rf_waddr !== ((i == 5) ? 5'd12 : 5'd13)) begin
            bad++; $display("FAIL starve_waddr cyc=%0d got=%0d exp=%0d", i, rf_waddr, (i == 5) ? 12 : 13); end
      end
      set_idle();
      tick();
   endtask

   task automatic test_waw();
      set_idle();
      lv = 1'b1; lrd = 5'd3; ldat = 32'h33;
      tick();
      set_idle();
      pv = 1'b1; prd = 5'd3; pdat = 32'h3333;
      tick();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h3333) begin
         bad++; $display("FAIL waw_pipe got=%b/%0d/%h exp=1/3/3333", rf_we, rf_waddr, rf_wdata); end
      set_idle();
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL waw_killed_we cyc=%0d got=%b exp=0", i, rf_we); end
      end
      lv = 1'b1; lrd = 5'd4; ldat = 32'h44;
      pv = 1'b1; prd = 5'd4; pdat = 32'h4444;
      tick();
      total++; if (rf_waddr !== 5'd4 || rf_wdata !== 32'h4444) begin
         bad++; $display("FAIL waw_same_pipe got=%0d/%h exp=4/4444", rf_waddr, rf_wdata); end
      set_idle();
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL waw_same_we cyc=%0d got=%b exp=0", i, rf_we); end
      end
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL waw_ready got=%b exp=1", ld_ready); end
   endtask

   task automatic test_x0_reset();
      set_idle();
      lv = 1'b1; lrd = 5'd0; ldat = 32'hBAD;
      tick();
      set_idle();
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL x0_we cyc=%0d got=%b exp=0", i, rf_we); end
      end
      lv = 1'b1; lrd = 5'd6; ldat = 32'h66;
      tick();
      set_idle();
      rst_n = 1'b0;
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL midrst_we got=%b exp=0", rf_we); end
      total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", ld_ready); end
      rst_n = 1'b1;
      tick();
      total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_ready got=%b exp=1", ld_ready); end
      tick();
      total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL midrst_discard_we got=%b exp=0", rf_we); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         pv    = $urandom_range(0, 1);
         prd   = 5'($urandom_range(0, 5));
         pdat  = $urandom;
         lv    = $urandom_range(0, 1);
         lrd   = 5'($urandom_range(0, 5));
         ldat  = $urandom;
         tick();
         total++; if (act_stall !== exp_stall) begin
            bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, act_stall, exp_stall); end
         total++; if (act_ready !== exp_ready) begin
            bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", c, act_ready, exp_ready); end
         total++; if (rf_we !== m_we) begin
            bad++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, rf_we, m_we); end
         total++; if (rf_waddr !== m_addr) begin
            bad++; $display("FAIL rnd_waddr cyc=%0d got=%0d exp=%0d", c, rf_waddr, m_addr); end
         total++; if (rf_wdata !== m_data) begin
            bad++; $display("FAIL rnd_wdata cyc=%0d got=%h exp=%h", c, rf_wdata, m_data); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      set_idle();
      test_reset();
      test_pipe_only();
      test_load_idle();
      test_full();
      test_starve();
      test_waw();
      test_x0_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port of the RV32I core between the in-order pipeline write-back result (ALU / load-byte / PC+4 / U-immediate select) and a variable-latency load-response path. Load responses are buffered in a small queue, granted when the pipeline leaves the port idle or when the queue becomes full or starved, and cancelled when a younger pipeline write targets the same register. Sits between the write-back select stage and the register file; drives the registered write port.

## Interface
- XLEN, 32, data width
- REG_AW, 5, register address width
- LQ_DEPTH, 2, load queue entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive pipeline wins tolerated while the queue is non-empty
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- pipe_valid  in  1  pipeline write-back request
- pipe_rd  in  REG_AW  destination register
- pipe_data  in  XLEN  write-back data
- pipe_stall  out  1  combinational; pipeline must hold its request this cycle
- ld_valid  in  1  load response valid
- ld_ready  out  1  registered; queue can accept
- ld_rd  in  REG_AW  load destination
- ld_data  in  XLEN  load data
- rf_we  out  1  registered write enable
- rf_waddr  out  REG_AW  registered write address
- rf_wdata  out  XLEN  registered write data

## Operation
- Queue entry: {rd, data, kill}. Enqueue on ld_valid && ld_ready; ld_rd == 0 enqueues with kill = 1.
- Arbitration each cycle, over the live (non-killed) queue head H and the pipeline request P (P exists iff pipe_valid && pipe_rd != 0):
  - queue full, or starve_cnt == STARVE_MAX with queue non-empty -> H wins; pipe_stall = pipe_valid.
  - else P present -> P wins; starve_cnt increments (saturating) if the queue is non-empty.
  - else H present -> H wins.
- starve_cnt clears whenever H wins or the queue is empty.
- pipe_valid with pipe_rd == 0: consumed without a write, never stalled unless H wins by the full/starve rule.
- A killed head is popped in any cycle without using the port, at most one pop per cycle, concurrent with a P grant.
- WAW cancel: when P is granted, every queue entry with rd == pipe_rd sets kill. This includes an entry enqueued in the same cycle, which is treated as older than P.
- Winner is registered into rf_we / rf_waddr / rf_wdata. With no winner, rf_we = 0 and addr/data hold their values.

## Timing
- Reset (rst_n low at an edge): rf_we = 0, rf_waddr = 0, rf_wdata = 0, queue empty, starve_cnt = 0, ld_ready = 0. ld_ready is 1 from the first cycle after reset release.
- Pipeline latency: granted in cycle N -> rf_we high in cycle N+1.
- Load latency: accepted in cycle N -> earliest grant N+1 -> rf_we in N+2.
- ld_ready = !full, computed from registered count. A pop in the same cycle does not raise ld_ready until the next cycle.
- Simultaneous enqueue and dequeue while full: not possible (ld_ready = 0). While non-full: count is unchanged.
- Reset mid-operation: queued loads are discarded; rf_we is low in the cycle after the reset edge.

## Structure
- Package wb_pkg: XLEN, REG_AW, lq_entry_t struct {rd, data, kill}, grant-source enum {GNT_NONE, GNT_PIPE, GNT_LOAD}.
- Sub-module wb_load_fifo: circular buffer with read/write pointers, registered count, full/empty flags, and a per-entry kill-by-rd match port.
- Top level holds the arbiter, the starve counter and the output registers.

## Test plan
- Pipe only: pipe_valid, rd = 5, data = 0x1234 in cycle 1 -> rf_we = 1, waddr = 5, wdata = 0x1234 in cycle 2; pipe_stall never asserted.
- Load into idle port: ld_valid, rd = 7, data = 0xDEADBEEF in cycle 1 -> rf_we, waddr = 7 in cycle 3; ld_ready stays 1.
- Full queue: two loads queued while pipe_valid is continuously high -> pipe_stall = 1 next cycle, load rd written, ld_ready low while count == 2.
- Starvation: one queued load, pipe_valid high every cycle, STARVE_MAX = 4 -> the load wins on the 5th cycle and pipe_stall = 1 for exactly that cycle.
- WAW cancel: load rd = 3 queued, then pipe rd = 3 granted -> only the pipe write to x3 appears; the load is popped with no write.
- x0 and reset: load rd = 0 produces no write; asserting rst_n = 0 with one load queued -> queue empty and rf_we = 0 after the edge, and ld_ready = 1 one cycle after release.
